// File: rtl/ex_mem_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, bundled as one bus.
// The slave modport is the stage's view; the master modport is the view of whoever drives it.
interface ex_mem_if #(
    parameter int XLEN = 32
);
    logic            bubble_i;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] pc4_i;
    logic [XLEN-1:0] pc_imm_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] A_i;
    logic [XLEN-1:0] rD2_i;
    logic            ALU_B_sel_i;
    logic [3:0]      ALU_op_i;
    logic [1:0]      pc_sel_i;
    logic [1:0]      wD_sel_i;
    logic            RegWrite_i;
    logic            wr_i_i;

    logic [XLEN-1:0] EX_to_ID;
    logic [4:0]      ex_rd_o;
    logic            ex_load_o;
    logic            jump_o;
    logic [XLEN-1:0] pc_target_o;
    logic [XLEN-1:0] alu_res_o;
    logic [XLEN-1:0] rD2_o;
    logic [XLEN-1:0] pc4_o;
    logic [XLEN-1:0] imm_o;
    logic [4:0]      rd_o;
    logic [1:0]      wD_sel_o;
    logic            RegWrite_o;
    logic            wr_o;
    logic            bubble_o;

    modport slave (
        input  bubble_i, inst_i, pc_i, pc4_i, pc_imm_i, imm_i, A_i, rD2_i,
               ALU_B_sel_i, ALU_op_i, pc_sel_i, wD_sel_i, RegWrite_i, wr_i_i,
        output EX_to_ID, ex_rd_o, ex_load_o, jump_o, pc_target_o, alu_res_o, rD2_o,
               pc4_o, imm_o, rd_o, wD_sel_o, RegWrite_o, wr_o, bubble_o
    );

    modport master (
        output bubble_i, inst_i, pc_i, pc4_i, pc_imm_i, imm_i, A_i, rD2_i,
               ALU_B_sel_i, ALU_op_i, pc_sel_i, wD_sel_i, RegWrite_i, wr_i_i,
        input  EX_to_ID, ex_rd_o, ex_load_o, jump_o, pc_target_o, alu_res_o, rD2_o,
               pc4_o, imm_o, rd_o, wD_sel_o, RegWrite_o, wr_o, bubble_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// RV32I execute stage with EX/MEM pipeline register: ALU, branch resolution and a
// registered one-cycle redirect that also kills the wrong-path instruction behind it.
//
//   state | meaning
//   RUN   | EX slot executes normally; a live taken branch/jump raises the redirect
//   FLUSH | redirect pulse is out; the instruction now in EX is wrong-path and killed
module ex_mem_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
    input  logic      clk,
    input  logic      reset,
    ex_mem_if.slave   bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            jump_q, jump_d;
    logic [XLEN-1:0] pc_target_q;
    logic [XLEN-1:0] alu_res_q, rD2_q, pc4_q, imm_q;
    logic [4:0]      rd_q;
    logic [1:0]      wD_sel_q;
    logic            reg_write_q, wr_q, bubble_q;

    logic [XLEN-1:0] alu_b, alu_res, jalr_sum, target;
    logic [4:0]      shamt;
    logic            cond, taken, live;
    logic            unused_bits;

    assign alu_b = bus.ALU_B_sel_i ? bus.imm_i : bus.rD2_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = bus.A_i + alu_b;
        case (bus.ALU_op_i)
            4'd1:    alu_res = bus.A_i - alu_b;
            4'd2:    alu_res = bus.A_i & alu_b;
            4'd3:    alu_res = bus.A_i | alu_b;
            4'd4:    alu_res = bus.A_i ^ alu_b;
            4'd5:    alu_res = bus.A_i << shamt;
            4'd6:    alu_res = bus.A_i >> shamt;
            4'd7:    alu_res = $unsigned($signed(bus.A_i) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(bus.A_i) < $signed(alu_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, bus.A_i < alu_b};
            4'd10:   alu_res = alu_b;
            default: alu_res = bus.A_i + alu_b;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (bus.inst_i[14:12])
            3'b000:  cond = (bus.A_i == bus.rD2_i);
            3'b001:  cond = (bus.A_i != bus.rD2_i);
            3'b100:  cond = ($signed(bus.A_i) <  $signed(bus.rD2_i));
            3'b101:  cond = ($signed(bus.A_i) >= $signed(bus.rD2_i));
            3'b110:  cond = (bus.A_i <  bus.rD2_i);
            3'b111:  cond = (bus.A_i >= bus.rD2_i);
            default: cond = 1'b0;
        endcase
    end

    assign jalr_sum = bus.A_i + bus.imm_i;
    assign target   = (bus.pc_sel_i == 2'd3) ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pc_imm_i;
    assign taken    = (bus.pc_sel_i[1]) || ((bus.pc_sel_i == 2'd1) && cond);
    assign live     = ~bus.bubble_i && (state_q == ST_RUN);

    // In FLUSH live is 0, so the FSM always falls back to RUN and the pulse lasts one cycle.
    assign jump_d  = live && taken;
    assign state_d = jump_d ? ST_FLUSH : ST_RUN;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            jump_q      <= 1'b0;
            pc_target_q <= '0;
            bubble_q    <= 1'b1;
            reg_write_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 5'd0;
            wD_sel_q    <= 2'd0;
            alu_res_q   <= '0;
            rD2_q       <= '0;
            imm_q       <= '0;
            pc4_q       <= RESET_PC4;
        end else begin
            state_q     <= state_d;
            jump_q      <= jump_d;
            if (jump_d) pc_target_q <= target;
            bubble_q    <= ~live;
            reg_write_q <= live & bus.RegWrite_i;
            wr_q        <= live & bus.wr_i_i;
            rd_q        <= live ? bus.inst_i[11:7] : 5'd0;
            wD_sel_q    <= bus.wD_sel_i;
            alu_res_q   <= alu_res;
            rD2_q       <= bus.rD2_i;
            imm_q       <= bus.imm_i;
            pc4_q       <= bus.pc4_i;
        end
    end

    assign bus.EX_to_ID    = alu_res;
    assign bus.ex_rd_o     = live ? bus.inst_i[11:7] : 5'd0;
    assign bus.ex_load_o   = live && (bus.wD_sel_i == 2'd1) && bus.RegWrite_i;
    assign bus.jump_o      = jump_q;
    assign bus.pc_target_o = pc_target_q;
    assign bus.alu_res_o   = alu_res_q;
    assign bus.rD2_o       = rD2_q;
    assign bus.pc4_o       = pc4_q;
    assign bus.imm_o       = imm_q;
    assign bus.rd_o        = rd_q;
    assign bus.wD_sel_o    = wD_sel_q;
    assign bus.RegWrite_o  = reg_write_q;
    assign bus.wr_o        = wr_q;
    assign bus.bubble_o    = bubble_q;

    assign unused_bits = ^{bus.pc_i, bus.inst_i[31:15], bus.inst_i[6:0], jalr_sum[0]};
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: ALU vector table, directed redirect/squash/reset
// sequences, then randomized traffic against a behavioural model.
module tb_ex_mem_stage;
    localparam logic [31:0] RST_PC4 = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_if #(.XLEN(32)) bus ();

    ex_mem_stage #(.XLEN(32), .RESET_PC4(RST_PC4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        bsel;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return a + b;
        endcase
    endfunction

    function automatic bit cond_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return int'(a) < int'(b);
            3'b101:  return int'(a) >= int'(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        bus.bubble_i    = 1'b1;
        bus.inst_i      = 32'h0000_0013;
        bus.pc_i        = 32'h0;
        bus.pc4_i       = 32'h4;
        bus.pc_imm_i    = 32'h0;
        bus.imm_i       = 32'h0;
        bus.A_i         = 32'h0;
        bus.rD2_i       = 32'h0;
        bus.ALU_B_sel_i = 1'b0;
        bus.ALU_op_i    = 4'd0;
        bus.pc_sel_i    = 2'd0;
        bus.wD_sel_i    = 2'd0;
        bus.RegWrite_i  = 1'b0;
        bus.wr_i_i      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        bit          flush;
        logic [31:0] tgt_hold;

        vecs[0]  = '{4'd0,  32'd5,         32'd7,       32'd0,      1'b0, 32'd12};
        vecs[1]  = '{4'd1,  32'd5,         32'd7,       32'd0,      1'b0, 32'hFFFF_FFFE};
        vecs[2]  = '{4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,    1'b0, 32'h0000_F000};
        vecs[3]  = '{4'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,    1'b0, 32'h0000_FFF0};
        vecs[4]  = '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,    1'b0, 32'h0000_0FF0};
        vecs[5]  = '{4'd5,  32'd1,         32'd31,      32'd0,      1'b0, 32'h8000_0000};
        vecs[6]  = '{4'd5,  32'd1,         32'd33,      32'd0,      1'b0, 32'h0000_0002};
        vecs[7]  = '{4'd6,  32'h8000_0000, 32'd4,       32'd0,      1'b0, 32'h0800_0000};
        vecs[8]  = '{4'd7,  32'h8000_0000, 32'd4,       32'd0,      1'b0, 32'hF800_0000};
        vecs[9]  = '{4'd8,  32'hFFFF_FFFF, 32'd1,       32'd0,      1'b0, 32'd1};
        vecs[10] = '{4'd9,  32'hFFFF_FFFF, 32'd1,       32'd0,      1'b0, 32'd0};
        vecs[11] = '{4'd10, 32'h1111_1111, 32'd9,       32'h1234,   1'b1, 32'h0000_1234};
        vecs[12] = '{4'd14, 32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE};

        // Reset state
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_jump", {31'd0, bus.jump_o}, 32'd0);
        chk("rst_target", bus.pc_target_o, 32'd0);
        chk("rst_bubble", {31'd0, bus.bubble_o}, 32'd1);
        chk("rst_regwrite", {31'd0, bus.RegWrite_o}, 32'd0);
        chk("rst_rd", {27'd0, bus.rd_o}, 32'd0);
        chk("rst_pc4", bus.pc4_o, RST_PC4);
        chk("rst_alu", bus.alu_res_o, 32'd0);

        // ALU vector table
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            idle();
            bus.bubble_i    = 1'b0;
            bus.inst_i      = {20'd0, 5'(i + 1), 7'h33};
            bus.ALU_op_i    = vecs[i].op;
            bus.A_i         = vecs[i].a;
            bus.rD2_i       = vecs[i].rd2;
            bus.imm_i       = vecs[i].imm;
            bus.ALU_B_sel_i = vecs[i].bsel;
            bus.RegWrite_i  = 1'b1;
            #1;
            chk($sformatf("vec%0d_ex_to_id", i), bus.EX_to_ID, vecs[i].exp);
            tick();
            chk($sformatf("vec%0d_alu_res", i), bus.alu_res_o, vecs[i].exp);
            chk($sformatf("vec%0d_rd", i), {27'd0, bus.rd_o}, i + 1);
            chk($sformatf("vec%0d_regwrite", i), {31'd0, bus.RegWrite_o}, 32'd1);
            chk($sformatf("vec%0d_bubble", i), {31'd0, bus.bubble_o}, 32'd0);
            chk($sformatf("vec%0d_jump", i), {31'd0, bus.jump_o}, 32'd0);
            @(negedge clk);
        end

        // BEQ taken, then wrong-path ADD squashed in the FLUSH cycle
        idle();
        bus.bubble_i = 1'b0;
        bus.inst_i   = {17'd0, 3'b000, 5'd0, 7'h63};
        bus.A_i      = 32'd9;
        bus.rD2_i    = 32'd9;
        bus.pc_imm_i = 32'h100;
        bus.pc_sel_i = 2'd1;
        tick();
        chk("beq_jump", {31'd0, bus.jump_o}, 32'd1);
        chk("beq_target", bus.pc_target_o, 32'h100);
        @(negedge clk);
        idle();
        bus.bubble_i   = 1'b0;
        bus.inst_i     = {20'd0, 5'd7, 7'h33};
        bus.A_i        = 32'd1;
        bus.rD2_i      = 32'd2;
        bus.RegWrite_i = 1'b1;
        bus.wr_i_i     = 1'b1;
        bus.wD_sel_i   = 2'd1;
        #1;
        chk("squash_ex_rd", {27'd0, bus.ex_rd_o}, 32'd0);
        chk("squash_ex_load", {31'd0, bus.ex_load_o}, 32'd0);
        tick();
        chk("squash_bubble", {31'd0, bus.bubble_o}, 32'd1);
        chk("squash_regwrite", {31'd0, bus.RegWrite_o}, 32'd0);
        chk("squash_wr", {31'd0, bus.wr_o}, 32'd0);
        chk("squash_jump", {31'd0, bus.jump_o}, 32'd0);
        chk("squash_target_hold", bus.pc_target_o, 32'h100);
        // Same ADD again, now live
        @(negedge clk);
        #1;
        chk("live_ex_load", {31'd0, bus.ex_load_o}, 32'd1);
        tick();
        chk("live_wr", {31'd0, bus.wr_o}, 32'd1);
        chk("live_rd", {27'd0, bus.rd_o}, 32'd7);

        // BNE with equal operands: not taken
        @(negedge clk);
        idle();
        bus.bubble_i = 1'b0;
        bus.inst_i   = {17'd0, 3'b001, 5'd0, 7'h63};
        bus.A_i      = 32'd4;
        bus.rD2_i    = 32'd4;
        bus.pc_imm_i = 32'h300;
        bus.pc_sel_i = 2'd1;
        tick();
        chk("bne_nt_jump", {31'd0, bus.jump_o}, 32'd0);

        // JALR, then reset during the FLUSH cycle
        @(negedge clk);
        idle();
        bus.bubble_i   = 1'b0;
        bus.inst_i     = {20'd0, 5'd1, 7'h67};
        bus.A_i        = 32'h203;
        bus.imm_i      = 32'h10;
        bus.pc_sel_i   = 2'd3;
        bus.wD_sel_i   = 2'd2;
        bus.pc4_i      = 32'h44;
        bus.RegWrite_i = 1'b1;
        tick();
        chk("jalr_jump", {31'd0, bus.jump_o}, 32'd1);
        chk("jalr_target", bus.pc_target_o, 32'h212);
        chk("jalr_pc4", bus.pc4_o, 32'h44);
        chk("jalr_wdsel", {30'd0, bus.wD_sel_o}, 32'd2);
        @(negedge clk);
        idle();
        bus.bubble_i   = 1'b0;
        bus.RegWrite_i = 1'b1;
        reset = 1'b0;
        tick();
        chk("rstfl_jump", {31'd0, bus.jump_o}, 32'd0);
        chk("rstfl_bubble", {31'd0, bus.bubble_o}, 32'd1);
        chk("rstfl_regwrite", {31'd0, bus.RegWrite_o}, 32'd0);
        // State back in RUN: a JAL right after reset must redirect
        @(negedge clk);
        reset = 1'b1;
        idle();
        bus.bubble_i = 1'b0;
        bus.pc_sel_i = 2'd2;
        bus.pc_imm_i = 32'h500;
        tick();
        chk("post_rst_jump", {31'd0, bus.jump_o}, 32'd1);
        chk("post_rst_target", bus.pc_target_o, 32'h500);

        // Randomized traffic against the model
        @(negedge clk);
        idle();
        reset = 1'b0;
        tick();
        flush    = 1'b0;
        tgt_hold = 32'h0;
        for (int n = 0; n < 400; n++) begin
            bit          rst_n, live, taken;
            logic [31:0] b, res, tgt;
            logic [4:0]  rd;
            @(negedge clk);
            rst_n           = ($urandom_range(0, 39) != 0);
            reset           = rst_n;
            bus.bubble_i    = ($urandom_range(0, 3) == 0);
            bus.inst_i      = $urandom;
            bus.pc_i        = $urandom;
            bus.pc4_i       = $urandom;
            bus.pc_imm_i    = $urandom;
            bus.imm_i       = $urandom;
            bus.A_i         = $urandom;
            bus.rD2_i       = ($urandom_range(0, 3) == 0) ? bus.A_i : $urandom;
            bus.ALU_B_sel_i = 1'($urandom);
            bus.ALU_op_i    = 4'($urandom);
            bus.pc_sel_i    = 2'($urandom);
            bus.wD_sel_i    = 2'($urandom);
            bus.RegWrite_i  = 1'($urandom);
            bus.wr_i_i      = 1'($urandom);

            rd    = bus.inst_i[11:7];
            live  = !bus.bubble_i && !flush;
            b     = bus.ALU_B_sel_i ? bus.imm_i : bus.rD2_i;
            res   = alu_model(bus.ALU_op_i, bus.A_i, b);
            taken = (bus.pc_sel_i >= 2) ||
                    (bus.pc_sel_i == 1 && cond_model(bus.inst_i[14:12], bus.A_i, bus.rD2_i));
            tgt   = (bus.pc_sel_i == 3) ? ((bus.A_i + bus.imm_i) & 32'hFFFF_FFFE) : bus.pc_imm_i;
            #1;
            chk("rnd_ex_to_id", bus.EX_to_ID, res);
            chk("rnd_ex_rd", {27'd0, bus.ex_rd_o}, live ? {27'd0, rd} : 32'd0);
            chk("rnd_ex_load", {31'd0, bus.ex_load_o},
                (live && bus.wD_sel_i == 2'd1 && bus.RegWrite_i) ? 32'd1 : 32'd0);
            tick();
            if (!rst_n) begin
                flush    = 1'b0;
                tgt_hold = 32'h0;
                chk("rnd_rst_jump", {31'd0, bus.jump_o}, 32'd0);
                chk("rnd_rst_target", bus.pc_target_o, 32'd0);
                chk("rnd_rst_bubble", {31'd0, bus.bubble_o}, 32'd1);
                chk("rnd_rst_pc4", bus.pc4_o, RST_PC4);
                chk("rnd_rst_alu", bus.alu_res_o, 32'd0);
            end else begin
                if (live && taken) tgt_hold = tgt;
                flush = live && taken;
                chk("rnd_jump", {31'd0, bus.jump_o}, {31'd0, flush});
                chk("rnd_target", bus.pc_target_o, tgt_hold);
                chk("rnd_bubble", {31'd0, bus.bubble_o}, {31'd0, !live});
                chk("rnd_regwrite", {31'd0, bus.RegWrite_o}, {31'd0, live && bus.RegWrite_i});
                chk("rnd_wr", {31'd0, bus.wr_o}, {31'd0, live && bus.wr_i_i});
                chk("rnd_rd", {27'd0, bus.rd_o}, live ? {27'd0, rd} : 32'd0);
                chk("rnd_alu", bus.alu_res_o, res);
                chk("rnd_rd2", bus.rD2_o, bus.rD2_i);
                chk("rnd_pc4", bus.pc4_o, bus.pc4_i);
                chk("rnd_imm", bus.imm_o, bus.imm_i);
                chk("rnd_wdsel", {30'd0, bus.wD_sel_o}, {30'd0, bus.wD_sel_i});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
